// File: rtl/param_seq_detector.sv
// -----------------------------------------------------------------------------
// param_seq_detector
//
// Serial pattern detector. Accepted bits are shifted into a short history
// register; a match is flagged combinationally (Mealy) in the same cycle as
// the bit that completes the pattern. Overlapping or non-overlapping
// detection is selected per accepted bit. The target pattern can be reloaded
// at run time, which also flushes the history.
//
// Optional feature: define SEQDET_COUNT_EN to build the saturating match
// counter (match_cnt / cnt_clear). Without it match_cnt is tied to 0,
// cnt_clear is ignored and no counter flops exist.
//
// Parameters
//   WIDTH           pattern length in bits (2..16)
//   DEFAULT_PATTERN pattern loaded by reset
//   COUNT_W         match counter width
//
// Ports
//   clk           in   clock, rising edge
//   reset         in   asynchronous reset, active low
//   in_bit        in   serial data bit
//   in_valid      in   in_bit is accepted this cycle
//   pattern       in   new target pattern, MSB first in time
//   pattern_load  in   latch pattern and flush history (wins over in_valid)
//   overlap_en    in   1 = overlapping detection, 0 = non-overlapping
//   cnt_clear     in   synchronous clear of match_cnt (wins over a match)
//   out           out  match pulse, same cycle as the completing bit
//   match_cnt     out  saturating match count
// -----------------------------------------------------------------------------
module param_seq_detector #(
    parameter int                 WIDTH           = 4,
    parameter logic [WIDTH-1:0]   DEFAULT_PATTERN = WIDTH'(4'b1011),
    parameter int                 COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_bit,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   pattern,
    input  logic               pattern_load,
    input  logic               overlap_en,
    input  logic               cnt_clear,
    output logic               out,
    output logic [COUNT_W-1:0] match_cnt
);

    localparam int              FILL_W   = $clog2(WIDTH);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH - 1);

    logic [WIDTH-1:0]  pat_q,  pat_d;
    logic [WIDTH-2:0]  hist_q, hist_d;   // most recent bit at LSB
    logic [FILL_W-1:0] fill_q, fill_d;   // number of valid history bits

    logic [WIDTH-1:0]  cand;
    logic              match;

    assign cand  = {hist_q, in_bit};
    assign match = in_valid & ~pattern_load & (fill_q == FILL_MAX) & (cand == pat_q);

    // Gated with reset so out is quiet while reset is held, independent of
    // the flop state.
    assign out = match & reset;

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (pattern_load) begin
            pat_d  = pattern;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            if (match) begin
                if (overlap_en) begin
                    // keep the trailing bits; fill stays full so the next
                    // match can complete with a single further bit
                    hist_d = cand[WIDTH-2:0];
                end else begin
                    hist_d = '0;
                    fill_d = '0;
                end
            end else begin
                hist_d = cand[WIDTH-2:0];
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q  <= DEFAULT_PATTERN;
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

`ifdef SEQDET_COUNT_EN
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clear) begin
            cnt_d = '0;
        end else if (match && (cnt_q != {COUNT_W{1'b1}})) begin
            cnt_d = cnt_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    logic unused_cnt_clear;

    assign unused_cnt_clear = cnt_clear;
    assign match_cnt        = '0;
`endif

endmodule

// File: tb/tb_param_seq_detector.sv
module tb_param_seq_detector;

    localparam int W = 4;
    localparam logic [W-1:0] DEF_PAT = 4'b1011;
`ifdef SEQDET_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_bit;
    logic         in_valid;
    logic [W-1:0] pattern;
    logic         pattern_load;
    logic         overlap_en;
    logic         cnt_clear;
    logic         out_a, out_b;
    logic [7:0]   cnt_a;
    logic [1:0]   cnt_b;

    always #5 clk = ~clk;

    param_seq_detector dut_a (
        .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
        .pattern(pattern), .pattern_load(pattern_load), .overlap_en(overlap_en),
        .cnt_clear(cnt_clear), .out(out_a), .match_cnt(cnt_a)
    );

    param_seq_detector #(.COUNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
        .pattern(pattern), .pattern_load(pattern_load), .overlap_en(overlap_en),
        .cnt_clear(cnt_clear), .out(out_b), .match_cnt(cnt_b)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: list of accepted bits since the last flush, oldest first.
    bit           hq[$];
    logic [W-1:0] m_pat;
    int           m_cnt8, m_cnt2;

    function automatic bit model_match(input bit b, input bit v, input bit ld);
        int n;
        if (!v || ld) return 1'b0;
        n = hq.size();
        if (n < W - 1) return 1'b0;
        for (int i = 0; i < W - 1; i++)
            if (hq[n - (W - 1) + i] != m_pat[W - 1 - i]) return 1'b0;
        return b == m_pat[0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic step(input bit b, input bit v, input bit ld,
                        input logic [W-1:0] p, input bit ovl, input bit clr);
        bit m;
        in_bit = b; in_valid = v; pattern_load = ld; pattern = p;
        overlap_en = ovl; cnt_clear = clr;
        #3;
        m = model_match(b, v, ld);
        check("out_a", {31'd0, out_a}, {31'd0, m});
        check("out_b", {31'd0, out_b}, {31'd0, m});
        @(posedge clk); #1;
        if (ld) begin
            m_pat = p;
            hq.delete();
        end else if (v) begin
            if (m && !ovl) hq.delete();
            else begin
                hq.push_back(b);
                if (hq.size() > W - 1) void'(hq.pop_front());
            end
        end
        if (clr) begin
            m_cnt8 = 0; m_cnt2 = 0;
        end else if (m) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3)   m_cnt2++;
        end
        check("cnt_a", {24'd0, cnt_a}, CNT_EN ? m_cnt8 : 0);
        check("cnt_b", {30'd0, cnt_b}, CNT_EN ? m_cnt2 : 0);
    endtask

    // Asserts reset mid-cycle with a completing-looking bit on the inputs.
    task automatic do_reset();
        reset = 1'b0; in_valid = 1'b1; in_bit = 1'b1; pattern_load = 1'b0;
        #1;
        check("rst_out_a", {31'd0, out_a}, 0);
        check("rst_out_b", {31'd0, out_b}, 0);
        check("rst_cnt_a", {24'd0, cnt_a}, 0);
        check("rst_cnt_b", {30'd0, cnt_b}, 0);
        in_valid = 1'b0;
        hq.delete(); m_pat = DEF_PAT; m_cnt8 = 0; m_cnt2 = 0;
        #1 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic stream(input logic [15:0] bits, input int n, input bit ovl);
        logic [15:0] s;
        s = bits;
        for (int i = n - 1; i >= 0; i--) step(s[i], 1'b1, 1'b0, '0, ovl, 1'b0);
    endtask

    initial begin
        reset = 1'b0; in_bit = 1'b0; in_valid = 1'b0; pattern = '0;
        pattern_load = 1'b0; overlap_en = 1'b1; cnt_clear = 1'b0;
        hq.delete(); m_pat = DEF_PAT; m_cnt8 = 0; m_cnt2 = 0;
        @(posedge clk); #1;
        do_reset();

        // Overlapping: 1011011 -> matches on bits 4 and 7.
        stream(16'b1011011, 7, 1'b1);
        // Flush history and clear counters, then non-overlapping.
        step(1'b0, 1'b0, 1'b1, DEF_PAT, 1'b0, 1'b1);
        stream(16'b1011011, 7, 1'b0);

        // Partial 1011 history, then load 0110 (coincident bit discarded).
        step(1'b0, 1'b0, 1'b1, DEF_PAT, 1'b1, 1'b1);
        stream(16'b101, 3, 1'b1);
        step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0);
        stream(16'b0110, 4, 1'b1);

        // Gaps of in_valid=0 hold the history.
        step(1'b0, 1'b0, 1'b1, DEF_PAT, 1'b1, 1'b1);
        stream(16'b101, 3, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);

        // Five overlapping matches (2-bit counter saturates), then a match
        // coincident with cnt_clear.
        step(1'b0, 1'b0, 1'b1, DEF_PAT, 1'b1, 1'b1);
        stream(16'b1011011011011011, 16, 1'b1);
        step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1);

        // Reset between bits 3 and 4 of 1011: no match spans it.
        stream(16'b101, 3, 1'b1);
        do_reset();
        step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);

        // Long run of matches to saturate the 8-bit counter.
        step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);

        // Randomised traffic with small patterns-space so matches are common.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            step(1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 8,
                 $urandom_range(0, 39) == 0,
                 W'($urandom),
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 59) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
